dma_io_peripheral_eop: RTL and testbench

//  Peripheral-side model of the DMA DREQ/DACK/EOP protocol: the I/O device that requests DMA, sources bytes on I/O-read cycles, and terminates a block.

---
 rtl/dma_io_peripheral_eop_if.sv | 35 +++
 rtl/dma_io_peripheral_eop.sv | 169 ++++++++++++++++
 tb/tb_dma_io_peripheral_eop.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_io_peripheral_eop_if.sv
// Signal bundle between the DMA controller/testbench side and the I/O
// peripheral that requests DMA, sources bytes and signals end-of-process.
interface dma_io_peripheral_eop_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 16
);
  logic              start;
  logic [LEN_W-1:0]  blk_len;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              DREQ;
  logic              DACK;
  logic              IOR_N;
  logic              EOP_N_IN;
  logic              EOP_N_OE;
  logic [DATA_W-1:0] DB_OUT;
  logic              DB_OE;
  logic              busy;
  logic              done;
  logic              tc_seen;
  logic [LEN_W-1:0]  xfer_cnt;

  // Peripheral side
  modport slave (
    input  start, blk_len, wr_valid, wr_data, DACK, IOR_N, EOP_N_IN,
    output wr_ready, DREQ, EOP_N_OE, DB_OUT, DB_OE, busy, done, tc_seen, xfer_cnt
  );

  // Controller / producer side
  modport master (
    output start, blk_len, wr_valid, wr_data, DACK, IOR_N, EOP_N_IN,
    input  wr_ready, DREQ, EOP_N_OE, DB_OUT, DB_OE, busy, done, tc_seen, xfer_cnt
  );
endinterface

// File: rtl/dma_io_peripheral_eop.sv
// DMA I/O peripheral: buffers producer bytes in a small FIFO, requests DMA
// with DREQ, drives bytes on I/O-read cycles, asserts EOP on the last byte of
// its block and stops early on a controller-driven EOP (terminal count).
module dma_io_peripheral_eop #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  dma_io_peripheral_eop_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, XFER, FIN} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [AW:0]       count_nxt;
  logic [LEN_W-1:0]  blk_len_q;
  logic [LEN_W-1:0]  xfer_cnt_q;
  logic              dreq_q;
  logic              busy_q;
  logic              done_q;
  logic              tc_q;
  logic              ior_n_p1;
  logic              in_xfer;
  logic              io_rd;
  logic              ior_rise;
  logic              push;
  logic              pop;
  logic              last;
  logic              next_last;
  logic              ext_eop;

  assign in_xfer   = (state == XFER);
  assign io_rd     = in_xfer & bus.DACK & ~bus.IOR_N;
  assign ior_rise  = bus.IOR_N & ~ior_n_p1;
  // A byte completes on the trailing edge of the read strobe while acknowledged
  assign pop       = in_xfer & bus.DACK & ior_rise;
  assign last      = ((xfer_cnt_q + LEN_W'(1)) == blk_len_q);
  assign next_last = ((xfer_cnt_q + LEN_W'(2)) == blk_len_q);
  // A full FIFO still takes a byte when the head leaves in the same cycle
  assign bus.wr_ready = (count != (AW+1)'(DEPTH)) | pop;
  assign push      = bus.wr_valid & bus.wr_ready;
  // Our own EOP pull also lowers the wired line; only foreign EOP counts
  assign ext_eop   = ((state == REQ) | in_xfer) & ~bus.EOP_N_IN & ~bus.EOP_N_OE;

  assign bus.DB_OE    = io_rd;
  assign bus.EOP_N_OE = io_rd & last;
  assign bus.DB_OUT   = in_xfer ? mem[rd_ptr] : '0;
  assign bus.DREQ     = dreq_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.tc_seen  = tc_q;
  assign bus.xfer_cnt = xfer_cnt_q;

  // Occupancy after this cycle's push/pop
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + (AW+1)'(1);
    else if (pop && !push) count_nxt = count - (AW+1)'(1);
  end

  // FIFO storage (data, no reset)
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= bus.wr_data;
  end

  // FIFO pointers, occupancy and read-strobe history
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ior_n_p1 <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count    <= count_nxt;
      ior_n_p1 <= bus.IOR_N;
    end
  end

  // Block sequencing FSM with registered request/status outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      dreq_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      tc_q       <= 1'b0;
      xfer_cnt_q <= '0;
      blk_len_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          dreq_q <= 1'b0;
          if (bus.start) begin
            blk_len_q  <= bus.blk_len;
            xfer_cnt_q <= '0;
            tc_q       <= 1'b0;
            if (bus.blk_len != '0) begin
              state  <= REQ;
              busy_q <= 1'b1;
            end else begin
              state  <= FIN;
              done_q <= 1'b1;
            end
          end
        end
        REQ: begin
          if (ext_eop) begin
            tc_q   <= 1'b1;
            dreq_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else if (bus.DACK && dreq_q) begin
            // Drop the request early when this byte empties us or ends the block
            state  <= XFER;
            dreq_q <= !((count == (AW+1)'(1)) || last);
          end else begin
            dreq_q <= (count != '0);
          end
        end
        XFER: begin
          if (pop) xfer_cnt_q <= xfer_cnt_q + LEN_W'(1);
          if (ext_eop) begin
            tc_q   <= 1'b1;
            dreq_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else if (pop && last) begin
            dreq_q <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= FIN;
          end else if (pop) begin
            if (count_nxt != '0) begin
              dreq_q <= !((count_nxt == (AW+1)'(1)) || next_last);
            end else begin
              dreq_q <= 1'b0;
              state  <= REQ;
            end
          end else if (!bus.DACK) begin
            dreq_q <= (count != '0);
            state  <= REQ;
          end else begin
            dreq_q <= !((count == (AW+1)'(1)) || last);
          end
        end
        FIN: begin
          dreq_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // The FSM only pops in XFER, which it enters with data present
  pop_not_empty: assert property (@(posedge CLK) disable iff (RESET) !(pop && (count == '0)));
endmodule

// File: tb/tb_dma_io_peripheral_eop.sv
// Bench for the DMA I/O peripheral: a byte scoreboard fed by producer pushes
// and drained on DMA read cycles, a table of block scenarios, and
// hand-written sequences for underflow, full FIFO, edge starts and reset.
module tb_dma_io_peripheral_eop;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  dma_io_peripheral_eop_if #(.DATA_W(8), .LEN_W(16)) bus ();

  dma_io_peripheral_eop #(.DATA_W(8), .DEPTH(4), .LEN_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  typedef struct {
    int unsigned blk_len;
    int unsigned n_push;
    int unsigned eop_after;  // 0: block runs to its own end
    int unsigned exp_cnt;
    bit          exp_tc;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] sb [$];
  int         n_cmp = 0;
  int         n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_take(output logic [7:0] v);
    if (sb.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_underrun: got empty expected data");
      v = 8'h00;
    end else begin
      v = sb.pop_front();
    end
  endtask

  task automatic push_byte(input logic [7:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    #1;
    chk("wr_ready_push", bus.wr_ready, 1);
    sb.push_back(d);
    step();
    bus.wr_valid = 1'b0;
  endtask

  task automatic start_blk(input int unsigned len);
    bus.start   = 1'b1;
    bus.blk_len = 16'(len);
    step();
    bus.start   = 1'b0;
  endtask

  // One DMA single-byte cycle: wait for DREQ, acknowledge, read strobe
  task automatic do_byte(input bit is_last);
    int         waited;
    logic [7:0] want;
    bus.DACK = 1'b0;
    step();
    waited = 0;
    while (!bus.DREQ && waited < 50) begin
      step();
      waited++;
    end
    chk("dreq_wait", bus.DREQ, 1);
    bus.DACK = 1'b1;
    step();
    bus.IOR_N = 1'b0;
    #1;
    sb_take(want);
    chk("db_oe", bus.DB_OE, 1);
    chk("db_out", bus.DB_OUT, want);
    chk("eop_oe", bus.EOP_N_OE, is_last);
    step();
    bus.IOR_N = 1'b1;
    #1;
    chk("db_oe_off", bus.DB_OE, 0);
    chk("eop_oe_off", bus.EOP_N_OE, 0);
    step();
    chk("done_after_byte", bus.done, is_last);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] want;

    vecs[0] = '{blk_len: 3, n_push: 3, eop_after: 0, exp_cnt: 3, exp_tc: 1'b0};
    vecs[1] = '{blk_len: 8, n_push: 4, eop_after: 2, exp_cnt: 2, exp_tc: 1'b1};
    vecs[2] = '{blk_len: 2, n_push: 0, eop_after: 0, exp_cnt: 2, exp_tc: 1'b0};
    vecs[3] = '{blk_len: 1, n_push: 1, eop_after: 0, exp_cnt: 1, exp_tc: 1'b0};
    vecs[4] = '{blk_len: 4, n_push: 4, eop_after: 1, exp_cnt: 1, exp_tc: 1'b1};
    vecs[5] = '{blk_len: 3, n_push: 0, eop_after: 0, exp_cnt: 3, exp_tc: 1'b0};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.blk_len  = '0;
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
    bus.DACK     = 1'b0;
    bus.IOR_N    = 1'b1;
    bus.EOP_N_IN = 1'b1;
    step();
    step();
    chk("rst_dreq", bus.DREQ, 0);
    chk("rst_eop_oe", bus.EOP_N_OE, 0);
    chk("rst_db_oe", bus.DB_OE, 0);
    chk("rst_db_out", bus.DB_OUT, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tc", bus.tc_seen, 0);
    chk("rst_cnt", bus.xfer_cnt, 0);
    chk("rst_wr_ready", bus.wr_ready, 1);
    rst = 1'b0;
    step();

    // Table-driven blocks; FIFO leftovers carry over between entries
    for (int i = 0; i < 6; i++) begin
      int unsigned nb;
      for (int p = 0; p < int'(vecs[i].n_push); p++) push_byte(8'($urandom_range(0, 255)));
      start_blk(vecs[i].blk_len);
      chk("busy_on_start", bus.busy, 1);
      nb = (vecs[i].eop_after != 0) ? vecs[i].eop_after : vecs[i].blk_len;
      for (int b = 0; b < int'(nb); b++)
        do_byte((vecs[i].eop_after == 0) && (b == int'(vecs[i].blk_len) - 1));
      if (vecs[i].eop_after != 0) begin
        bus.DACK     = 1'b0;
        bus.EOP_N_IN = 1'b0;
        step();
        bus.EOP_N_IN = 1'b1;
        chk("ext_eop_done", bus.done, 1);
        chk("ext_eop_dreq", bus.DREQ, 0);
      end
      chk("blk_cnt", bus.xfer_cnt, vecs[i].exp_cnt);
      chk("blk_tc", bus.tc_seen, 32'(vecs[i].exp_tc));
      chk("blk_busy", bus.busy, 0);
      bus.DACK = 1'b0;
      step();
      chk("done_pulse_end", bus.done, 0);
      chk("cnt_held", bus.xfer_cnt, vecs[i].exp_cnt);
    end

    // Underflow: DREQ drops with the FIFO empty and returns one cycle after a push
    push_byte(8'h5A);
    start_blk(4);
    do_byte(1'b0);
    chk("uf_dreq_drop", bus.DREQ, 0);
    bus.DACK = 1'b0;
    step();
    step();
    chk("uf_dreq_idle", bus.DREQ, 0);
    push_byte(8'hC3);
    chk("uf_dreq_same", bus.DREQ, 0);
    step();
    chk("uf_dreq_back", bus.DREQ, 1);
    push_byte(8'h11);
    push_byte(8'h22);
    do_byte(1'b0);
    do_byte(1'b0);
    do_byte(1'b1);
    chk("uf_cnt", bus.xfer_cnt, 4);
    bus.DACK = 1'b0;
    step();

    // Full FIFO, push with simultaneous pop, then a demand-mode second byte
    push_byte(8'hA1);
    push_byte(8'hB2);
    push_byte(8'hC3);
    push_byte(8'hD4);
    chk("full_wr_ready", bus.wr_ready, 0);
    start_blk(2);
    step();
    chk("full_dreq", bus.DREQ, 1);
    bus.DACK = 1'b1;
    step();
    bus.IOR_N = 1'b0;
    #1;
    sb_take(want);
    chk("full_db_out0", bus.DB_OUT, want);
    chk("full_dreq_demand", bus.DREQ, 1);
    step();
    bus.IOR_N = 1'b1;
    push_byte(8'hE5);
    chk("full_after_pushpop", bus.wr_ready, 0);
    chk("full_cnt1", bus.xfer_cnt, 1);
    bus.IOR_N = 1'b0;
    #1;
    sb_take(want);
    chk("full_db_oe1", bus.DB_OE, 1);
    chk("full_db_out1", bus.DB_OUT, want);
    chk("full_eop_oe1", bus.EOP_N_OE, 1);
    chk("full_dreq_last", bus.DREQ, 0);
    step();
    bus.IOR_N = 1'b1;
    step();
    chk("full_done", bus.done, 1);
    chk("full_cnt2", bus.xfer_cnt, 2);
    bus.DACK = 1'b0;
    step();

    // Edge starts: zero length, and a start while busy
    start_blk(0);
    chk("zero_done", bus.done, 1);
    chk("zero_busy", bus.busy, 0);
    chk("zero_dreq", bus.DREQ, 0);
    step();
    chk("zero_done_end", bus.done, 0);
    chk("zero_dreq_after", bus.DREQ, 0);
    start_blk(3);
    start_blk(1);
    chk("ign_busy", bus.busy, 1);
    do_byte(1'b0);
    do_byte(1'b0);
    do_byte(1'b1);
    chk("ign_cnt", bus.xfer_cnt, 3);
    bus.DACK = 1'b0;
    step();

    // Reset in the middle of a read cycle
    push_byte(8'h77);
    push_byte(8'h88);
    start_blk(2);
    step();
    bus.DACK = 1'b1;
    step();
    bus.IOR_N = 1'b0;
    #1;
    chk("mid_db_oe", bus.DB_OE, 1);
    rst = 1'b1;
    step();
    chk("mid_rst_dreq", bus.DREQ, 0);
    chk("mid_rst_db_oe", bus.DB_OE, 0);
    chk("mid_rst_db_out", bus.DB_OUT, 0);
    chk("mid_rst_eop_oe", bus.EOP_N_OE, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_done", bus.done, 0);
    chk("mid_rst_cnt", bus.xfer_cnt, 0);
    chk("mid_rst_wr_ready", bus.wr_ready, 1);
    rst       = 1'b0;
    bus.DACK  = 1'b0;
    bus.IOR_N = 1'b1;
    sb.delete();
    step();
    chk("post_rst_done", bus.done, 0);
    start_blk(1);
    for (int k = 0; k < 4; k++) step();
    chk("post_rst_empty", bus.DREQ, 0);
    push_byte(8'h3C);
    do_byte(1'b1);
    chk("post_rst_cnt", bus.xfer_cnt, 1);
    bus.DACK = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
